// File: rtl/ask_pkg.sv
// ASK link shared constants and helpers.
// Used by both the modulator and the demodulator.
package ask_pkg;

   localparam int ASK_MID        = 32767;
   localparam int ASK_BIT_PERIOD = 9766;
   localparam int ASK_NBITS      = 16;
   localparam int ASK_THRESH     = 4096;
   localparam int ASK_MIN_HITS   = 2441;
   localparam int ASK_QUIET_MIN  = 2000;
   localparam int ASK_HITS_W     = 14;

   // |s - mid| on offset-binary samples, 17-bit signed difference
   function automatic logic [15:0] off_mag(
      input logic [15:0] s,
      input logic [15:0] mid
   );
      logic signed [16:0] d;
      d = $signed({1'b0, s}) - $signed({1'b0, mid});
      return 16'(d[16] ? -d : d);
   endfunction

endpackage

// File: rtl/ask_env_det.sv
// ASK envelope detector: magnitude, threshold, quiet-run tracking.
// rise marks the first active cycle after a long enough quiet run.
module ask_env_det import ask_pkg::*; #(
   parameter int MID       = ASK_MID,
   parameter int THRESH    = ASK_THRESH,
   parameter int QUIET_MIN = ASK_QUIET_MIN
) (
   input  logic        clk_100M,
   input  logic        rst,
   input  logic        frame_sync,
   input  logic [15:0] ask_in,
   output logic        active,
   output logic        rise
);

   localparam int QW = $clog2(QUIET_MIN + 1);
   localparam logic [QW-1:0] QMAX = QW'(QUIET_MIN);

   logic [15:0]   mag_q;
   logic          active_q;
   logic [QW-1:0] quiet_cnt;

   // two-stage magnitude and threshold pipeline
   always_ff @(posedge clk_100M) begin
      if (rst) begin
         mag_q    <= '0;
         active_q <= 1'b0;
      end else begin
         mag_q    <= off_mag(ask_in, 16'(MID));
         active_q <= (mag_q > 16'(THRESH));
      end
   end

   // length of the current inactive run, saturating
   always_ff @(posedge clk_100M) begin
      if (rst || frame_sync) begin
         quiet_cnt <= '0;
      end else if (active_q) begin
         quiet_cnt <= '0;
      end else if (quiet_cnt != QMAX) begin
         quiet_cnt <= quiet_cnt + 1'b1;
      end
   end

   assign active = active_q;
   assign rise   = active_q && (quiet_cnt == QMAX);

endmodule

// File: rtl/ask_demod.sv
// ASK demodulator: bit timer, hit counter, slicer and word assembly.
// Envelope rises late in a window pull the bit timer into alignment.
module ask_demod import ask_pkg::*; #(
   parameter int BIT_PERIOD = ASK_BIT_PERIOD,
   parameter int MID        = ASK_MID,
   parameter int THRESH     = ASK_THRESH,
   parameter int MIN_HITS   = ASK_MIN_HITS,
   parameter int QUIET_MIN  = ASK_QUIET_MIN,
   parameter int NBITS      = ASK_NBITS
) (
   input  logic             clk_100M,
   input  logic             rst,
   input  logic [15:0]      ask_in,
   input  logic             frame_sync,
   output logic             bit_out,
   output logic             bit_valid,
   output logic [NBITS-1:0] code_out,
   output logic             code_valid,
   output logic             carrier_det
);

   localparam int CW = $clog2(BIT_PERIOD);
   localparam int IW = $clog2(NBITS);
   localparam int HW = ASK_HITS_W;

   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(BIT_PERIOD / 2);
   localparam logic [IW-1:0] IDX_LAST = IW'(NBITS - 1);
   localparam logic [HW-1:0] HITS_MAX = '1;
   localparam logic [HW-1:0] MINH     = HW'(MIN_HITS);

   logic             active;
   logic             rise;
   logic [CW-1:0]    bit_cnt;
   logic [IW-1:0]    bit_idx;
   logic [HW-1:0]    hits;
   logic [HW-1:0]    hits_inc;
   logic [NBITS-2:0] shreg;
   logic             natural_b;
   logic             forced_b;
   logic             boundary;
   logic             dec;

   ask_env_det #(
      .MID       (MID),
      .THRESH    (THRESH),
      .QUIET_MIN (QUIET_MIN)
   ) u_env (
      .clk_100M   (clk_100M),
      .rst        (rst),
      .frame_sync (frame_sync),
      .ask_in     (ask_in),
      .active     (active),
      .rise       (rise)
   );

   // window bookkeeping and the slicing decision
   always_comb begin
      hits_inc  = (active && hits != HITS_MAX) ? hits + 1'b1 : hits;
      natural_b = (bit_cnt == CNT_LAST);
      forced_b  = rise && (bit_cnt > CNT_HALF);
      boundary  = natural_b || forced_b;
      dec       = forced_b ? (hits >= MINH) : (hits_inc >= MINH);
   end

   // bit timer and hit counter; a forced boundary opens a window on the rise
   always_ff @(posedge clk_100M) begin
      if (rst || frame_sync) begin
         bit_cnt <= '0;
         hits    <= '0;
      end else if (forced_b) begin
         bit_cnt <= CW'(1);
         hits    <= HW'(1);
      end else if (natural_b) begin
         bit_cnt <= '0;
         hits    <= '0;
      end else begin
         bit_cnt <= bit_cnt + 1'b1;
         hits    <= hits_inc;
      end
   end

   // bit output, shift register and word assembly
   always_ff @(posedge clk_100M) begin
      if (rst) begin
         bit_out     <= 1'b0;
         bit_valid   <= 1'b0;
         code_out    <= '0;
         code_valid  <= 1'b0;
         carrier_det <= 1'b0;
         bit_idx     <= '0;
         shreg       <= '0;
      end else if (frame_sync) begin
         bit_valid  <= 1'b0;
         code_valid <= 1'b0;
         bit_idx    <= '0;
         shreg      <= '0;
      end else if (boundary) begin
         bit_out     <= dec;
         bit_valid   <= 1'b1;
         carrier_det <= dec;
         shreg       <= {shreg[NBITS-3:0], dec};
         if (bit_idx == IDX_LAST) begin
            code_out   <= {shreg, dec};
            code_valid <= 1'b1;
            bit_idx    <= '0;
         end else begin
            code_valid <= 1'b0;
            bit_idx    <= bit_idx + 1'b1;
         end
      end else begin
         bit_valid  <= 1'b0;
         code_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ask_demod.sv
// Testbench for ask_demod with a shortened bit period.
// Reference model works on sample history, window position and bit lists.
module tb_ask_demod;

   localparam int BP  = 200;
   localparam int MID = 32767;
   localparam int TH  = 4096;
   localparam int MH  = 50;
   localparam int QM  = 40;
   localparam int NB  = 16;

   logic        clk_100M = 1'b0;
   logic        rst = 1'b1;
   logic        frame_sync = 1'b0;
   logic [15:0] ask_in = 16'(MID);
   logic        bit_out;
   logic        bit_valid;
   logic [15:0] code_out;
   logic        code_valid;
   logic        carrier_det;

   ask_demod #(
      .BIT_PERIOD (BP),
      .MID        (MID),
      .THRESH     (TH),
      .MIN_HITS   (MH),
      .QUIET_MIN  (QM),
      .NBITS      (NB)
   ) dut (
      .clk_100M    (clk_100M),
      .rst         (rst),
      .ask_in      (ask_in),
      .frame_sync  (frame_sync),
      .bit_out     (bit_out),
      .bit_valid   (bit_valid),
      .code_out    (code_out),
      .code_valid  (code_valid),
      .carrier_det (carrier_det)
   );

   always #5 clk_100M = ~clk_100M;

   int n_tests = 0;
   int n_fail  = 0;
   int n_bits  = 0;
   int cyc     = 0;
   logic bitq[$];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // reference model state
   int          d1 = MID, d2 = MID;
   int          m_quiet = 0, m_pos = 0, m_hits = 0, m_idx = 0;
   logic [15:0] m_word = '0;
   logic        e_bit = 0, e_bv = 0, e_cv = 0, e_cd = 0;
   logic [15:0] e_code = '0;

   // model: what every output should be after each rising edge
   always @(posedge clk_100M) begin
      bit act, rs, frc, nat, dv;
      if (rst) begin
         d1 = MID; d2 = MID;
         m_quiet = 0; m_pos = 0; m_hits = 0; m_idx = 0;
         m_word = '0;
         e_bit = 0; e_bv = 0; e_cv = 0; e_cd = 0; e_code = '0;
      end else begin
         act = ((d2 > MID) ? d2 - MID : MID - d2) > TH;
         d2 = d1;
         d1 = int'(ask_in);
         rs = act && (m_quiet == QM);
         if (frame_sync || act) m_quiet = 0;
         else if (m_quiet < QM) m_quiet++;
         e_bv = 0;
         e_cv = 0;
         if (frame_sync) begin
            m_pos = 0; m_hits = 0; m_idx = 0; m_word = '0;
         end else begin
            frc = rs && (m_pos > BP / 2);
            nat = (m_pos == BP - 1);
            if (frc || nat) begin
               dv = frc ? (m_hits >= MH) : (m_hits + int'(act) >= MH);
               m_word = {m_word[14:0], dv};
               e_bit = dv; e_cd = dv; e_bv = 1;
               if (m_idx == NB - 1) begin
                  e_code = m_word; e_cv = 1; m_idx = 0; m_word = '0;
               end else begin
                  m_idx++;
               end
               m_pos  = frc ? 1 : 0;
               m_hits = frc ? 1 : 0;
            end else begin
               m_pos++;
               m_hits += int'(act);
            end
         end
      end
   end

   // compare DUT against the model away from the active edge
   always @(negedge clk_100M) begin
      cyc++;
      if (bit_valid || e_bv) begin
         check("bit_valid", 32'(bit_valid), 32'(e_bv));
         check("bit_out", 32'(bit_out), 32'(e_bit));
         check("carrier_det", 32'(carrier_det), 32'(e_cd));
      end
      if (code_valid || e_cv) begin
         check("code_valid", 32'(code_valid), 32'(e_cv));
         check("code_out", 32'(code_out), 32'(e_code));
      end
      if (cyc % 64 == 0)
         check("outs", {14'd0, bit_out, code_out, carrier_det},
               {14'd0, e_bit, e_code, e_cd});
      if (bit_valid) begin
         bitq.push_back(bit_out);
         n_bits++;
      end
   end

   int sin_t[8] = '{0, 707, 1000, 707, 0, -707, -1000, -707};

   function automatic logic [15:0] carrier(input int amp, input int ph);
      return 16'(MID + amp * sin_t[ph % 8] / 1000);
   endfunction

   task automatic step(input logic [15:0] v);
      ask_in = v;
      @(posedge clk_100M);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(16'(MID));
   endtask

   task automatic fsync();
      frame_sync = 1'b1;
      step(16'(MID));
      frame_sync = 1'b0;
   endtask

   task automatic send(input logic [15:0] w, input int amp, input int ncyc);
      for (int t = 0; t < ncyc; t++) begin
         int b;
         b = 15 - t / BP;
         step(w[b] ? carrier(amp, t) : 16'(MID));
      end
   endtask

   task automatic word_test(input string tag, input logic [15:0] w,
                            input int amp);
      int nb0;
      fsync();
      nb0 = n_bits;
      send(w, amp, NB * BP);
      idle(4);
      check({tag, "_code"}, 32'(code_out), 32'(w));
      check({tag, "_nbits"}, 32'(n_bits - nb0), 32'(NB));
   endtask

   initial begin
      int nb0;
      logic [16:0] v;
      repeat (10) step(16'(MID));
      check("reset_outs",
            {15'd0, bit_out, bit_valid, code_out, code_valid, carrier_det},
            32'd0);
      rst = 1'b0;
      idle(5);

      word_test("idle", 16'h0000, 0);
      check("idle_cd", 32'(carrier_det), 32'd0);

      word_test("a5c3", 16'hA5C3, 30000);
      check("a5c3_cd", 32'(carrier_det), 32'd1);

      word_test("ffff", 16'hFFFF, 30000);

      // late start: rise deep in window 8 forces a boundary
      fsync();
      nb0 = bitq.size();
      idle(140);
      send(16'h00FF, 30000, NB * BP);
      idle(2 * BP);
      v = '0;
      for (int i = 0; i < 17; i++) v = {v[15:0], bitq[nb0 + i]};
      check("late_bits", 32'(v), 32'h000FF);
      check("late_code", 32'(code_out), 32'h007F);

      // reset in the middle of a word
      fsync();
      nb0 = n_bits;
      send(16'h1234, 30000, 7 * BP + BP / 2);
      check("pre_rst_nbits", 32'(n_bits - nb0), 32'd7);
      rst = 1'b1;
      step(16'(MID));
      rst = 1'b0;
      check("rst_outs",
            {15'd0, bit_out, bit_valid, code_out, code_valid, carrier_det},
            32'd0);
      idle(BP + 10);
      check("rst_code_hold", 32'(code_out), 32'd0);
      word_test("post_rst", 16'h1234, 30000);

      // sub-threshold square noise
      fsync();
      nb0 = n_bits;
      for (int t = 0; t < NB * BP; t++) begin
         if (t % 2 == 1) step(16'(MID + int'($urandom_range(0, TH))));
         else step(16'(MID - int'($urandom_range(0, TH))));
      end
      idle(4);
      check("noise_code", 32'(code_out), 32'd0);
      check("noise_cd", 32'(carrier_det), 32'd0);
      check("noise_nbits", 32'(n_bits - nb0), 32'(NB));

      // random words at random carrier amplitude
      repeat (3) begin
         logic [15:0] w;
         int amp;
         w   = 16'($urandom);
         amp = int'($urandom_range(8000, 32000));
         word_test("rand", w, amp);
      end

      idle(20);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
